// File: rtl/mips_core_pkg.sv
// Shared core constants and the reorder-buffer entry layout; also imported by rename.
package mips_core_pkg;

  localparam int unsigned ROB_DEPTH      = 16;
  localparam int unsigned ROB_DEPTH_BITS = 4;
  localparam int unsigned PHY_REG_BITS   = 6;
  localparam int unsigned LOG_REG_BITS   = 5;

  typedef logic [ROB_DEPTH_BITS-1:0] rob_tag_t;
  typedef logic [ROB_DEPTH_BITS:0]   rob_ptr_t;

  typedef struct packed {
    logic                    valid;
    logic                    done;
    logic                    uses_rw;
    logic [LOG_REG_BITS-1:0] rw_log;
    logic [PHY_REG_BITS-1:0] rw_phy;
    logic [PHY_REG_BITS-1:0] old_phy;
    logic                    is_branch;
  } rob_entry_t;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? '1 : sum[31:0];
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocate at tail, complete out of order, commit at head, squash on flush.
// Optional ROB_PERF_EN adds saturating commit/squash counters.
module reorder_buffer
  import mips_core_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc_valid,
  input  logic                      alloc_uses_rw,
  input  logic [LOG_REG_BITS-1:0]   alloc_rw_log,
  input  logic [PHY_REG_BITS-1:0]   alloc_rw_phy,
  input  logic [PHY_REG_BITS-1:0]   alloc_old_phy,
  input  logic                      alloc_is_branch,
  output logic                      alloc_ready,
  output logic [ROB_DEPTH_BITS-1:0] alloc_tag,
  input  logic                      cmpl_valid,
  input  logic [ROB_DEPTH_BITS-1:0] cmpl_tag,
  input  logic                      flush_valid,
  input  logic [ROB_DEPTH_BITS-1:0] flush_tag,
  output logic                      reg_wr_en,
  output logic [PHY_REG_BITS-1:0]   reg_wr_addr,
  output logic [LOG_REG_BITS-1:0]   reg_wr_log,
  output logic                      free_en,
  output logic [PHY_REG_BITS-1:0]   free_phy,
  output logic                      commit_valid,
  output logic [ROB_DEPTH_BITS-1:0] commit_tag,
  output logic                      commit_is_branch,
  output logic [ROB_DEPTH_BITS:0]   rob_count,
  output logic                      rob_empty
`ifdef ROB_PERF_EN
  ,
  output logic [31:0]               perf_commits,
  output logic [31:0]               perf_squashed
`endif
);

  localparam rob_ptr_t FULL_COUNT = rob_ptr_t'(ROB_DEPTH);

  rob_entry_t           rob [ROB_DEPTH];
  rob_ptr_t             head, tail, count, tail_next, squash_n;
  rob_tag_t             head_idx, tail_idx, cmpl_off, flush_off;
  logic                 full, alloc_fire, cmpl_fire, commit_fire;
  logic                 cmpl_live, flush_live;
  logic [ROB_DEPTH-1:0] squash_mask;
  rob_entry_t           head_e;

  assign head_idx    = head[ROB_DEPTH_BITS-1:0];
  assign tail_idx    = tail[ROB_DEPTH_BITS-1:0];
  assign count       = tail - head;
  assign full        = (count == FULL_COUNT);
  assign alloc_ready = !full;
  assign alloc_tag   = tail_idx;
  assign rob_count   = count;
  assign rob_empty   = (count == '0);
  assign head_e      = rob[head_idx];

  // A tag is live when its distance from head falls inside the occupied window.
  assign cmpl_off    = cmpl_tag - head_idx;
  assign flush_off   = flush_tag - head_idx;
  assign cmpl_live   = cmpl_valid && rob[cmpl_tag].valid && ({1'b0, cmpl_off} < count);
  assign flush_live  = flush_valid && rob[flush_tag].valid && ({1'b0, flush_off} < count);
  assign cmpl_fire   = cmpl_live && !(flush_live && (cmpl_off > flush_off));
  assign commit_fire = !rob_empty && head_e.valid && head_e.done;
  assign alloc_fire  = alloc_valid && !full && !flush_valid;
  assign squash_n    = count - {1'b0, flush_off} - rob_ptr_t'(1);

  always_comb begin
    squash_mask = '0;
    for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
      if (flush_live
          && (rob_tag_t'(rob_tag_t'(i) - head_idx) > flush_off)
          && ({1'b0, rob_tag_t'(rob_tag_t'(i) - head_idx)} < count))
        squash_mask[i] = 1'b1;
    end
  end

  always_comb begin
    tail_next = tail;
    if (flush_live)
      tail_next = head + {1'b0, flush_off} + rob_ptr_t'(1);
    else if (alloc_fire)
      tail_next = tail + rob_ptr_t'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else begin
      tail <= tail_next;
      if (commit_fire)
        head <= head + rob_ptr_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ROB_DEPTH; i++)
        rob[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < ROB_DEPTH; i++)
        if (squash_mask[i])
          rob[i].valid <= 1'b0;
      if (alloc_fire)
        rob[tail_idx] <= '{valid: 1'b1, done: 1'b0, uses_rw: alloc_uses_rw,
                           rw_log: alloc_rw_log, rw_phy: alloc_rw_phy,
                           old_phy: alloc_old_phy, is_branch: alloc_is_branch};
      if (cmpl_fire)
        rob[cmpl_tag].done <= 1'b1;
      if (commit_fire) begin
        rob[head_idx].valid <= 1'b0;
        rob[head_idx].done  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !commit_fire) begin
      commit_valid     <= 1'b0;
      commit_tag       <= '0;
      commit_is_branch <= 1'b0;
      reg_wr_en        <= 1'b0;
      reg_wr_addr      <= '0;
      reg_wr_log       <= '0;
      free_en          <= 1'b0;
      free_phy         <= '0;
    end else begin
      commit_valid     <= 1'b1;
      commit_tag       <= head_idx;
      commit_is_branch <= head_e.is_branch;
      reg_wr_en        <= head_e.uses_rw;
      reg_wr_addr      <= head_e.rw_phy;
      reg_wr_log       <= head_e.rw_log;
      free_en          <= head_e.uses_rw;
      free_phy         <= head_e.old_phy;
    end
  end

`ifdef ROB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_commits  <= '0;
      perf_squashed <= '0;
    end else begin
      if (commit_fire)
        perf_commits <= sat_add32(perf_commits, 32'd1);
      if (flush_live)
        perf_squashed <= sat_add32(perf_squashed, 32'(squash_n));
    end
  end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: queue-based program-order model, directed scenarios, random traffic.
module tb_reorder_buffer;
  import mips_core_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      alloc_valid, alloc_uses_rw, alloc_is_branch;
  logic [LOG_REG_BITS-1:0]   alloc_rw_log;
  logic [PHY_REG_BITS-1:0]   alloc_rw_phy, alloc_old_phy;
  logic                      alloc_ready;
  logic [ROB_DEPTH_BITS-1:0] alloc_tag;
  logic                      cmpl_valid, flush_valid;
  logic [ROB_DEPTH_BITS-1:0] cmpl_tag, flush_tag;
  logic                      reg_wr_en, free_en, commit_valid, commit_is_branch;
  logic [PHY_REG_BITS-1:0]   reg_wr_addr, free_phy;
  logic [LOG_REG_BITS-1:0]   reg_wr_log;
  logic [ROB_DEPTH_BITS-1:0] commit_tag;
  logic [ROB_DEPTH_BITS:0]   rob_count;
  logic                      rob_empty;
`ifdef ROB_PERF_EN
  logic [31:0]               perf_commits, perf_squashed;
`endif

  reorder_buffer dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_uses_rw(alloc_uses_rw), .alloc_rw_log(alloc_rw_log),
    .alloc_rw_phy(alloc_rw_phy), .alloc_old_phy(alloc_old_phy), .alloc_is_branch(alloc_is_branch),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag),
    .flush_valid(flush_valid), .flush_tag(flush_tag),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_log(reg_wr_log),
    .free_en(free_en), .free_phy(free_phy),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_is_branch(commit_is_branch),
    .rob_count(rob_count), .rob_empty(rob_empty)
`ifdef ROB_PERF_EN
    , .perf_commits(perf_commits), .perf_squashed(perf_squashed)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int tag;
    bit done;
    bit uses_rw;
    int log_r;
    int phy;
    int old;
    bit br;
  } m_ent_t;

  m_ent_t q[$];
  int     m_tail;
  bit     e_cv, e_br, e_we;
  int     e_tag, e_wa, e_wl, e_fp;
  int     m_commits, m_squashed;
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_step(input bit r, input bit av, input bit au, input int alog,
                                     input int aphy, input int aold, input bit abr,
                                     input bit cv, input int ct, input bit fv, input int ft);
    int  fk;
    int  pre_size;
    bit  commit;
    m_ent_t e;
    if (r) begin
      q.delete();
      m_tail = 0;
      e_cv = 0; e_br = 0; e_we = 0; e_tag = 0; e_wa = 0; e_wl = 0; e_fp = 0;
      m_commits = 0; m_squashed = 0;
      return;
    end
    pre_size = q.size();
    commit = (pre_size > 0) && q[0].done;
    e_cv = commit;
    e_we = commit && q[0].uses_rw;
    if (commit) begin
      e_tag = q[0].tag; e_br = q[0].br; e_wa = q[0].phy; e_wl = q[0].log_r; e_fp = q[0].old;
    end
    fk = -1;
    if (fv)
      for (int k = 0; k < q.size(); k++)
        if (q[k].tag == ft) fk = k;
    if (cv)
      for (int k = 0; k < q.size(); k++)
        if (q[k].tag == ct && !(fk >= 0 && k > fk)) q[k].done = 1;
    if (fk >= 0) begin
      m_squashed += q.size() - fk - 1;
      while (q.size() > fk + 1) void'(q.pop_back());
      m_tail = (ft + 1) % ROB_DEPTH;
    end
    if (av && pre_size < ROB_DEPTH && !fv) begin
      e = '{tag: m_tail, done: 0, uses_rw: au, log_r: alog, phy: aphy, old: aold, br: abr};
      q.push_back(e);
      m_tail = (m_tail + 1) % ROB_DEPTH;
    end
    if (commit) begin
      void'(q.pop_front());
      m_commits++;
    end
  endfunction

  task automatic compare_all();
    chk("alloc_ready", alloc_ready, (q.size() < ROB_DEPTH) ? 1 : 0);
    chk("alloc_tag", alloc_tag, m_tail);
    chk("rob_count", rob_count, q.size());
    chk("rob_empty", rob_empty, (q.size() == 0) ? 1 : 0);
    chk("commit_valid", commit_valid, e_cv);
    chk("reg_wr_en", reg_wr_en, e_we);
    chk("free_en", free_en, e_we);
    if (e_cv) begin
      chk("commit_tag", commit_tag, e_tag);
      chk("commit_is_branch", commit_is_branch, e_br);
    end
    if (e_we) begin
      chk("reg_wr_addr", reg_wr_addr, e_wa);
      chk("reg_wr_log", reg_wr_log, e_wl);
      chk("free_phy", free_phy, e_fp);
    end
`ifdef ROB_PERF_EN
    chk("perf_commits", perf_commits, m_commits);
    chk("perf_squashed", perf_squashed, m_squashed);
`endif
  endtask

  task automatic cycle(input bit r, input bit av, input bit au, input int alog, input int aphy,
                       input int aold, input bit abr, input bit cv, input int ct,
                       input bit fv, input int ft);
    rst = r;
    alloc_valid = av; alloc_uses_rw = au; alloc_rw_log = alog[LOG_REG_BITS-1:0];
    alloc_rw_phy = aphy[PHY_REG_BITS-1:0]; alloc_old_phy = aold[PHY_REG_BITS-1:0];
    alloc_is_branch = abr;
    cmpl_valid = cv; cmpl_tag = ct[ROB_DEPTH_BITS-1:0];
    flush_valid = fv; flush_tag = ft[ROB_DEPTH_BITS-1:0];
    model_step(r, av, au, alog, aphy, aold, abr, cv, ct, fv, ft);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();                  cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic idle();                      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic cmpl(input int t);           cycle(0, 0, 0, 0, 0, 0, 0, 1, t, 0, 0); endtask
  task automatic flush(input int t);          cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, t); endtask
  task automatic alloc(input bit au, input int phy, input int old, input bit br);
    cycle(0, 1, au, phy % 32, phy, old, br, 0, 0, 0, 0);
  endtask

  task automatic rand_cycle();
    bit r, av, au, br, cv, fv;
    int ct, ft;
    r  = ($urandom_range(0, 399) == 0);
    av = ($urandom_range(0, 99) < 65);
    au = ($urandom_range(0, 99) < 75);
    br = ($urandom_range(0, 99) < 20);
    cv = ($urandom_range(0, 99) < 60);
    fv = ($urandom_range(0, 99) < 4);
    ct = (q.size() > 0 && $urandom_range(0, 99) < 85) ? q[$urandom_range(0, q.size() - 1)].tag
                                                        : int'($urandom_range(0, ROB_DEPTH - 1));
    ft = (q.size() > 0 && $urandom_range(0, 99) < 80) ? q[$urandom_range(0, q.size() - 1)].tag
                                                        : int'($urandom_range(0, ROB_DEPTH - 1));
    cycle(r, av, au, $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63), br,
          cv, ct, fv, ft);
  endtask

  initial begin
    rst = 1'b1;
    alloc_valid = 0; alloc_uses_rw = 0; alloc_rw_log = '0; alloc_rw_phy = '0;
    alloc_old_phy = '0; alloc_is_branch = 0; cmpl_valid = 0; cmpl_tag = '0;
    flush_valid = 0; flush_tag = '0;
    @(negedge clk);

    // In-order commit of out-of-order completions
    do_reset();
    chk("reset_ready", alloc_ready, 1);
    chk("reset_empty", rob_empty, 1);
    chk("reset_cv", commit_valid, 0);
    alloc(1, 32, 5, 0); alloc(1, 33, 6, 0); alloc(1, 34, 7, 0);
    chk("t1_count", rob_count, 3);
    cmpl(2);
    cmpl(0);
    chk("t1_no_commit_yet", commit_valid, 0);
    cmpl(1);
    chk("t1_c0_valid", commit_valid, 1);
    chk("t1_c0_tag", commit_tag, 0);
    chk("t1_c0_addr", reg_wr_addr, 32);
    chk("t1_c0_free", free_phy, 5);
    idle();
    chk("t1_c1_addr", reg_wr_addr, 33);
    chk("t1_c1_free", free_phy, 6);
    idle();
    chk("t1_c2_addr", reg_wr_addr, 34);
    chk("t1_c2_free", free_phy, 7);
    idle();
    chk("t1_empty", rob_empty, 1);

    // Full buffer and wrap
    do_reset();
    for (int i = 0; i < 16; i++) alloc(1, 40 + i, i, 0);
    chk("t2_full_ready", alloc_ready, 0);
    chk("t2_full_count", rob_count, 16);
    alloc(1, 1, 1, 0);
    chk("t2_17th_ignored", rob_count, 16);
    cmpl(0);
    alloc(1, 2, 2, 0);
    chk("t2_ready_again", alloc_ready, 1);
    chk("t2_count15", rob_count, 15);
    chk("t2_wrap_tag", alloc_tag, 0);
    alloc(1, 3, 3, 0);
    chk("t2_count16", rob_count, 16);

    // Branch mispredict squash
    do_reset();
    for (int i = 0; i < 8; i++) alloc(1, 10 + i, 20 + i, (i == 3));
    flush(3);
    chk("t3_count", rob_count, 4);
    chk("t3_tail", alloc_tag, 4);
`ifdef ROB_PERF_EN
    chk("t3_perf_sq", perf_squashed, 4);
`endif
    cmpl(5);
    chk("t3_stale_cmpl", rob_count, 4);
    for (int i = 0; i < 4; i++) cmpl(i);
    idle(); idle();
    chk("t3_drained", rob_empty, 1);

    // Flush at head while head commits
    do_reset();
    alloc(1, 50, 9, 1); alloc(1, 51, 8, 0); alloc(1, 52, 7, 0);
    cmpl(0);
    flush(0);
    chk("t4_empty", rob_empty, 1);
    chk("t4_cv", commit_valid, 1);
    chk("t4_branch", commit_is_branch, 1);

    // No destination register
    do_reset();
    alloc(0, 12, 13, 0);
    cmpl(0);
    idle();
    chk("t5_cv", commit_valid, 1);
    chk("t5_we", reg_wr_en, 0);
    chk("t5_fe", free_en, 0);

    // Reset with occupied entries
    for (int i = 0; i < 5; i++) alloc(1, i, i, 0);
    cmpl(1);
    do_reset();
    chk("t6_count", rob_count, 0);
    chk("t6_tag", alloc_tag, 0);
    chk("t6_cv", commit_valid, 0);
    chk("t6_we", reg_wr_en, 0);
    chk("t6_fe", free_en, 0);
    chk("t6_ctag", commit_tag, 0);

    for (int i = 0; i < 4000; i++) rand_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
